// File: rtl/pll_clock_supervisor_pkg.sv
// Shared types and helpers for the PLL clock supervisor.
package pll_clock_supervisor_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    HOLD_RST,
    RUN
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_clock_supervisor_ce_strobe_gen.sv
// One clock-enable channel: free-running divider, active only while enabled.
module ce_strobe_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 ce
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] last;

  // A divisor of 0 behaves like 1: strobe every enabled cycle.
  always_comb begin
    last = (div_q == '0) ? '0 : div_q - DIV_WIDTH'(1);
  end

  assign ce = enable && (cnt == last);

  // While disabled the latch tracks div, so it holds the value seen on the entry edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (!enable) begin
      cnt   <= '0;
      div_q <= div;
    end else if (ce) begin
      cnt   <= '0;
      div_q <= div;
    end else begin
      cnt   <= cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pll_clock_supervisor.sv
// Qualifies the PLL lock, sequences a held system reset, drives CE strobes
// and records lock losses seen while running.
module pll_clock_supervisor
  import pll_clock_supervisor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned NUM_CE             = 2,
  parameter int unsigned CE_DIV_WIDTH       = 16,
  parameter int unsigned LOSS_CNT_WIDTH     = 8
) (
  input  logic                           clock_in,
  input  logic                           reset,
  input  logic                           pll_locked,
  input  logic [NUM_CE*CE_DIV_WIDTH-1:0] ce_div,
  input  logic                           clear_status,
  output logic                           sys_reset,
  output logic                           ready,
  output logic [NUM_CE-1:0]              ce_out,
  output logic                           lock_lost_sticky,
  output logic [LOSS_CNT_WIDTH-1:0]      lock_loss_count
);

  localparam int unsigned SW = cnt_width(LOCK_STABLE_CYCLES);
  localparam int unsigned HW = cnt_width(RESET_HOLD_CYCLES);
  // Leave STABLE on the edge where the counter would reach LOCK_STABLE_CYCLES-1.
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;

  always_ff @(posedge clock_in) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_s = sync[SYNC_STAGES-1];

  state_t         state, next_state;
  logic [SW-1:0]  stable_cnt, stable_nxt;
  logic [HW-1:0]  hold_cnt, hold_nxt;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      stable_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= next_state;
      stable_cnt <= stable_nxt;
      hold_cnt   <= hold_nxt;
    end
  end

  always_comb begin
    next_state = state;
    stable_nxt = '0;
    hold_nxt   = '0;
    case (state)
      WAIT_LOCK: if (lock_s) next_state = STABLE;
      STABLE: begin
        if (!lock_s)                      next_state = WAIT_LOCK;
        else if (stable_cnt == STABLE_LAST) next_state = HOLD_RST;
        else                              stable_nxt = stable_cnt + SW'(1);
      end
      HOLD_RST: begin
        if (!lock_s)                 next_state = WAIT_LOCK;
        else if (hold_cnt == HOLD_LAST) next_state = RUN;
        else                         hold_nxt   = hold_cnt + HW'(1);
      end
      RUN:     if (!lock_s) next_state = WAIT_LOCK;
      default: next_state = WAIT_LOCK;
    endcase
  end

  logic                      loss;
  logic                      sys_reset_nxt, ready_nxt, sticky_nxt;
  logic [LOSS_CNT_WIDTH-1:0] count_nxt;

  // A loss on the same cycle as clear_status restarts the count at one.
  always_comb begin
    loss          = (state == RUN) && !lock_s;
    sys_reset_nxt = (next_state != RUN);
    ready_nxt     = (next_state == RUN);
    sticky_nxt    = lock_lost_sticky;
    count_nxt     = lock_loss_count;
    if (loss) begin
      sticky_nxt = 1'b1;
      if (clear_status)              count_nxt = LOSS_CNT_WIDTH'(1);
      else if (lock_loss_count != '1) count_nxt = lock_loss_count + LOSS_CNT_WIDTH'(1);
    end else if (clear_status) begin
      sticky_nxt = 1'b0;
      count_nxt  = '0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sys_reset        <= 1'b1;
      ready            <= 1'b0;
      lock_lost_sticky <= 1'b0;
      lock_loss_count  <= '0;
    end else begin
      sys_reset        <= sys_reset_nxt;
      ready            <= ready_nxt;
      lock_lost_sticky <= sticky_nxt;
      lock_loss_count  <= count_nxt;
    end
  end

  logic run_en;
  assign run_en = (state == RUN);

  for (genvar k = 0; k < NUM_CE; k++) begin : g_ce
    ce_strobe_gen #(
      .DIV_WIDTH(CE_DIV_WIDTH)
    ) u_ce (
      .clk    (clock_in),
      .reset  (reset),
      .enable (run_en),
      .div    (ce_div[k*CE_DIV_WIDTH +: CE_DIV_WIDTH]),
      .ce     (ce_out[k])
    );
  end

endmodule

// File: tb/tb_pll_clock_supervisor.sv
// Directed bench for pll_clock_supervisor with short lock/hold parameters.
module tb_pll_clock_supervisor;

  localparam int unsigned NUM_CE         = 2;
  localparam int unsigned CE_DIV_WIDTH   = 16;
  localparam int unsigned LOSS_CNT_WIDTH = 2;

  logic                           clock_in = 1'b0;
  logic                           reset = 1'b1;
  logic                           pll_locked = 1'b0;
  logic                           clear_status = 1'b0;
  logic [NUM_CE*CE_DIV_WIDTH-1:0] ce_div = '0;
  logic                           sys_reset;
  logic                           ready;
  logic [NUM_CE-1:0]              ce_out;
  logic                           lock_lost_sticky;
  logic [LOSS_CNT_WIDTH-1:0]      lock_loss_count;

  int checks = 0;
  int errors = 0;

  always #5 clock_in = ~clock_in;

  pll_clock_supervisor #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .RESET_HOLD_CYCLES (4),
    .NUM_CE            (NUM_CE),
    .CE_DIV_WIDTH      (CE_DIV_WIDTH),
    .LOSS_CNT_WIDTH    (LOSS_CNT_WIDTH)
  ) dut (
    .clock_in        (clock_in),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .ce_div          (ce_div),
    .clear_status    (clear_status),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .ce_out          (ce_out),
    .lock_lost_sticky(lock_lost_sticky),
    .lock_loss_count (lock_loss_count)
  );

  task automatic step();
    @(negedge clock_in);
  endtask

  // Cycles from the current negedge until sys_reset is seen low (60 = timed out).
  task automatic wait_release(output int n);
    n = 0;
    while (n < 60) begin
      step();
      n++;
      if (sys_reset === 1'b0) break;
    end
  endtask

  task automatic lose_lock();
    pll_locked = 1'b0;
    repeat (3) step();
    pll_locked = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b0; ce_div = '0;
    repeat (3) step();
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL reset_sys_reset got %b want 1", sys_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (ce_out !== 2'b00) begin errors++; $display("FAIL reset_ce_out got %b want 00", ce_out); end
    checks++; if (lock_lost_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", lock_lost_sticky); end
    checks++; if (lock_loss_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", lock_loss_count); end
  endtask

  task automatic test_clean_lock();
    int n;
    reset = 1'b0; pll_locked = 1'b1;
    wait_release(n);
    checks++; if (n < 13 || n > 15) begin errors++; $display("FAIL clean_latency got %0d want 14+-1", n); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clean_ready got %b want 1", ready); end
    checks++; if (lock_loss_count !== 2'd0) begin errors++; $display("FAIL clean_count got %0d want 0", lock_loss_count); end
  endtask

  task automatic test_glitch();
    int n;
    reset = 1'b1; pll_locked = 1'b0;
    step();
    reset = 1'b0; pll_locked = 1'b1;
    repeat (5) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_release(n);
    checks++; if (n < 13 || n > 15) begin errors++; $display("FAIL glitch_latency got %0d want 14+-1", n); end
    checks++; if (lock_lost_sticky !== 1'b0) begin errors++; $display("FAIL glitch_sticky got %b want 0", lock_lost_sticky); end
  endtask

  task automatic test_lock_loss();
    int n;
    lose_lock();
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL loss_sys_reset got %b want 1", sys_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready got %b want 0", ready); end
    checks++; if (lock_lost_sticky !== 1'b1) begin errors++; $display("FAIL loss_sticky got %b want 1", lock_lost_sticky); end
    checks++; if (lock_loss_count !== 2'd1) begin errors++; $display("FAIL loss_count got %0d want 1", lock_loss_count); end
    wait_release(n);
    checks++; if (n < 13 || n > 15) begin errors++; $display("FAIL relock_latency got %0d want 14+-1", n); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL relock_ready got %b want 1", ready); end
  endtask

  task automatic test_ce_dividers();
    int   n;
    logic exp0;
    reset = 1'b1; pll_locked = 1'b0;
    ce_div = {16'd0, 16'd4};
    repeat (2) step();
    reset = 1'b0; pll_locked = 1'b1;
    wait_release(n);
    checks++; if (n < 13 || n > 15) begin errors++; $display("FAIL ce_latency got %0d want 14+-1", n); end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) step();
      exp0 = (cyc <= 12) ? (cyc % 4 == 0) : (cyc == 16 || cyc == 18 || cyc == 20);
      checks++;
      if (ce_out !== {1'b1, exp0}) begin
        errors++; $display("FAIL ce_cycle%0d got %b want %b", cyc, ce_out, {1'b1, exp0});
      end
      if (cyc == 13) ce_div[15:0] = 16'd2;
    end
  endtask

  task automatic test_saturation_clear();
    int n;
    logic [1:0] exp;
    for (int i = 1; i <= 5; i++) begin
      lose_lock();
      exp = (i >= 3) ? 2'd3 : 2'(i);
      checks++; if (lock_loss_count !== exp) begin errors++; $display("FAIL sat_count%0d got %0d want %0d", i, lock_loss_count, exp); end
      wait_release(n);
    end
    checks++; if (lock_lost_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b want 1", lock_lost_sticky); end
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    checks++; if (lock_loss_count !== 2'd0) begin errors++; $display("FAIL clear_count got %0d want 0", lock_loss_count); end
    checks++; if (lock_lost_sticky !== 1'b0) begin errors++; $display("FAIL clear_sticky got %b want 0", lock_lost_sticky); end
    lose_lock();
    checks++; if (lock_loss_count !== 2'd1) begin errors++; $display("FAIL preclear_count got %0d want 1", lock_loss_count); end
    wait_release(n);
    pll_locked = 1'b0;
    repeat (2) step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    checks++; if (lock_loss_count !== 2'd1) begin errors++; $display("FAIL clear_on_loss_count got %0d want 1", lock_loss_count); end
    checks++; if (lock_lost_sticky !== 1'b1) begin errors++; $display("FAIL clear_on_loss_sticky got %b want 1", lock_lost_sticky); end
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL clear_on_loss_sys_reset got %b want 1", sys_reset); end
  endtask

  task automatic test_mid_reset();
    int n;
    pll_locked = 1'b1;
    repeat (12) step();
    reset = 1'b1;
    step();
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL hold_rst_sys_reset got %b want 1", sys_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_rst_ready got %b want 0", ready); end
    checks++; if (lock_lost_sticky !== 1'b0) begin errors++; $display("FAIL hold_rst_sticky got %b want 0", lock_lost_sticky); end
    checks++; if (lock_loss_count !== 2'd0) begin errors++; $display("FAIL hold_rst_count got %0d want 0", lock_loss_count); end
    reset = 1'b0;
    wait_release(n);
    checks++; if (n < 13 || n > 15) begin errors++; $display("FAIL after_rst_latency got %0d want 14+-1", n); end
    repeat (5) step();
    checks++; if (ce_out[1] !== 1'b1) begin errors++; $display("FAIL run_ce1 got %b want 1", ce_out[1]); end
    reset = 1'b1;
    step();
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL run_rst_sys_reset got %b want 1", sys_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL run_rst_ready got %b want 0", ready); end
    checks++; if (ce_out !== 2'b00) begin errors++; $display("FAIL run_rst_ce_out got %b want 00", ce_out); end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_lock();
    test_glitch();
    test_lock_loss();
    test_ce_dividers();
    test_saturation_clear();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
